// File: rtl/lmsm_sequencer.sv
// Fetch-to-decode micro-sequencer: expands LM/SM into one LW/SW per mask bit,
// passes every other instruction through with one cycle of latency.
module lmsm_sequencer #(
    parameter logic [3:0] LM_OPC = 4'b0110,
    parameter logic [3:0] SM_OPC = 4'b0111,
    parameter logic [3:0] LW_OPC = 4'b0100,
    parameter logic [3:0] SW_OPC = 4'b0101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t      r_state, w_state_nx;
    logic        r_sm, w_sm_nx;
    logic [2:0]  r_base, w_base_nx;
    logic [7:0]  r_mask, w_mask_nx;
    logic [3:0]  r_count, w_count_nx;
    logic [15:0] r_pc, w_pc_nx;
    logic        r_out_valid, w_out_valid_nx;
    logic [15:0] r_out_instr, w_out_instr_nx;
    logic [15:0] r_out_pc, w_out_pc_nx;
    logic        r_out_last, w_out_last_nx;

    logic        w_idle, w_adv, w_acc, w_is_mult;
    logic        w_sm;
    logic [2:0]  w_base, w_idx, w_k;
    logic [7:0]  w_src, w_rem;
    logic [15:0] w_uop;

    assign w_idle    = (r_state == IDLE);
    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_idle && w_adv && !flush;
    assign w_acc     = in_valid && in_ready;
    assign w_is_mult = (in_instr[15:12] == LM_OPC) || (in_instr[15:12] == SM_OPC);

    // One encoder serves both the first micro-op (from fetch) and the rest.
    assign w_src  = w_idle ? in_instr[7:0] : r_mask;
    assign w_sm   = w_idle ? (in_instr[15:12] == SM_OPC) : r_sm;
    assign w_base = w_idle ? in_instr[11:9] : r_base;
    assign w_k    = w_idle ? 3'd0 : r_count[2:0];

    // Mask bit 7 is R0, so the lowest register is the highest set bit.
    always_comb begin
        w_idx = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (w_src[b]) w_idx = 3'(7 - b);
        end
    end

    assign w_rem = w_src & ~(8'h80 >> w_idx);
    assign w_uop = {(w_sm ? SW_OPC : LW_OPC), w_idx, w_base, 3'b000, w_k};

    always_comb begin
        w_state_nx     = r_state;
        w_sm_nx        = r_sm;
        w_base_nx      = r_base;
        w_mask_nx      = r_mask;
        w_count_nx     = r_count;
        w_pc_nx        = r_pc;
        w_out_valid_nx = r_out_valid;
        w_out_instr_nx = r_out_instr;
        w_out_pc_nx    = r_out_pc;
        w_out_last_nx  = r_out_last;
        if (flush) begin
            w_out_valid_nx = 1'b0;
            w_out_last_nx  = 1'b0;
            w_state_nx     = IDLE;
            w_mask_nx      = 8'd0;
            w_count_nx     = 4'd0;
        end else if (w_adv) begin
            w_out_valid_nx = 1'b0;
            if (!w_idle) begin
                w_out_valid_nx = 1'b1;
                w_out_instr_nx = w_uop;
                w_out_pc_nx    = r_pc;
                w_out_last_nx  = (w_rem == 8'd0);
                w_mask_nx      = w_rem;
                w_count_nx     = r_count + 4'd1;
                w_state_nx     = (w_rem == 8'd0) ? IDLE : SEQ;
            end else if (w_acc && !w_is_mult) begin
                w_out_valid_nx = 1'b1;
                w_out_instr_nx = in_instr;
                w_out_pc_nx    = in_pc;
                w_out_last_nx  = 1'b1;
            end else if (w_acc && (in_instr[7:0] != 8'd0)) begin
                w_sm_nx        = w_sm;
                w_base_nx      = w_base;
                w_pc_nx        = in_pc;
                w_out_valid_nx = 1'b1;
                w_out_instr_nx = w_uop;
                w_out_pc_nx    = in_pc;
                w_out_last_nx  = (w_rem == 8'd0);
                w_mask_nx      = w_rem;
                w_count_nx     = 4'd1;
                w_state_nx     = (w_rem == 8'd0) ? IDLE : SEQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sm        <= 1'b0;
            r_base      <= 3'd0;
            r_mask      <= 8'd0;
            r_count     <= 4'd0;
            r_pc        <= 16'd0;
            r_out_valid <= 1'b0;
            r_out_instr <= 16'd0;
            r_out_pc    <= 16'd0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_sm        <= w_sm_nx;
            r_base      <= w_base_nx;
            r_mask      <= w_mask_nx;
            r_count     <= w_count_nx;
            r_pc        <= w_pc_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_instr <= w_out_instr_nx;
            r_out_pc    <= w_out_pc_nx;
            r_out_last  <= w_out_last_nx;
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign out_last  = r_out_last;
    assign busy      = (r_state == SEQ);

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: accepted instructions are expanded
// by a reference model into a queue that the output monitor drains.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush;
    logic [15:0] in_instr, in_pc;
    logic        out_valid, out_ready, out_last, busy;
    logic [15:0] out_instr, out_pc;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        last;
    } uop_t;

    uop_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    lmsm_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: one LW/SW per set mask bit, registers ascending, offsets 0..n-1.
    function automatic void model_push(input logic [15:0] ins,
                                       input logic [15:0] pc);
        uop_t u;
        int   n, k;
        logic [3:0] op;
        op = ins[15:12];
        if (op == 4'd6 || op == 4'd7) begin
            n = $countones(ins[7:0]);
            k = 0;
            for (int r = 0; r < 8; r++) begin
                if (ins[7 - r]) begin
                    u.instr = {(op == 4'd7) ? 4'd5 : 4'd4, 3'(r), ins[11:9], 6'(k)};
                    u.pc    = pc;
                    u.last  = (k == n - 1);
                    exp_q.push_back(u);
                    k++;
                end
            end
        end else begin
            u.instr = ins;
            u.pc    = pc;
            u.last  = 1'b1;
            exp_q.push_back(u);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL uop: got %h/%h/%b expected none",
                         out_instr, out_pc, out_last);
            end else begin
                uop_t e;
                e = exp_q.pop_front();
                chk("uop", {out_instr, out_pc, out_last}, {15'd0, e});
            end
        end
    end

    // A flush cycle never has a transfer on the output side, so the
    // whole outstanding expectation can be discarded.
    task automatic drive(input logic v, input logic [15:0] ins,
                         input logic [15:0] pc, input logic ordy,
                         input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        flush     = fl;
        out_ready = fl ? 1'b0 : ordy;
        #1;
        if (v && in_ready) model_push(ins, pc);
        if (fl) exp_q.delete();
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        end
        if (i == 60) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] x;
        int sel;
        x   = 16'($urandom);
        sel = $urandom_range(0, 3);
        if (sel == 0) x[15:12] = 4'd6;
        else if (sel == 1) x[15:12] = 4'd7;
        else if (x[15:12] == 4'd6 || x[15:12] == 4'd7) x[15:12] = 4'd0;
        if (sel < 2 && $urandom_range(0, 7) == 0) x[7:0] = 8'd0;
        return x;
    endfunction

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_instr = 16'h0; in_pc = 16'h0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {out_valid, out_instr, out_pc, out_last, busy}, 35'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;

        drive(1'b1, 16'h1298, 16'h0010, 1'b1, 1'b0);
        chk("pt_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("pt_out", {out_valid, out_instr, out_pc, out_last}, {1'b1, 16'h1298, 16'h0010, 1'b1});
        chk("pt_in_ready2", {31'd0, in_ready}, 32'd1);
        drain();

        drive(1'b1, 16'h64A1, 16'h0020, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("lm0", {out_instr, out_last, busy, in_ready}, {16'h4080, 3'b010});
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("lm1", {out_instr, out_last, busy, in_ready}, {16'h4481, 3'b010});
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("lm2", {out_instr, out_last, busy, in_ready}, {16'h4E82, 3'b101});
        drain();

        drive(1'b1, 16'h7AFF, 16'h0030, 1'b1, 1'b0);
        drain();

        drive(1'b1, 16'h64A1, 16'h0040, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            chk("stall_hold", {15'd0, out_valid, out_instr}, {15'd0, 1'b1, 16'h4080});
        end
        drain();

        drive(1'b1, 16'h6400, 16'h0050, 1'b1, 1'b0);
        chk("zm_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 16'h1298, 16'h0052, 1'b1, 1'b0);
        chk("zm_no_out", {30'd0, out_valid, in_ready}, 32'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("zm_next", {15'd0, out_valid, out_instr}, {15'd0, 1'b1, 16'h1298});
        drain();

        drive(1'b1, 16'h64A1, 16'h0060, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("fl_pre", {16'd0, out_instr}, {16'd0, 16'h4481});
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("fl_post", {30'd0, out_valid, busy}, 32'd0);
        repeat (4) drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

        drive(1'b1, 16'h7AFF, 16'h0070, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", {out_valid, out_instr, out_pc, out_last, busy}, 35'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 9) < 7), rand_instr(), 16'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
